uart_mmio: RTL and testbench

- Memory-mapped 8N1 UART peripheral at 0x1000_0020–0x1000_002F.
- Sits directly downstream of the memory manager's UART port. Consumes its en/we/wdata strobes plus address bits [3:2], and returns read data combinationally in the same cycle.
- Contains a 1-deep TX holding register feeding a TX shifter, an RX deserializer with a 1-byte receive buffer, status/error flags, and a runtime-programmable baud divisor.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx.sv | 102 ++++++++++
 rtl/uart_mmio.sv | 201 ++++++++++++++++++++
 tb/tb_uart_mmio.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register indices, STATUS bit
// positions, the common TX/RX state encoding and the divisor floor.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_BUSY   = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_OVERRUN   = 3;
    localparam int ST_FRAME_ERR = 4;

    localparam int DIV_MIN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, mid-bit sampling FSM, and a one-cycle
// completion pulse (good byte or framing error) at the stop-bit sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx,
    input  logic [DIV_W-1:0] i_div_eff,
    output logic             o_byte_valid,
    output logic [7:0]       o_byte,
    output logic             o_frame_err
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [1:0]       r_sync;
    uart_state_t      r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             w_rx;
    logic             w_expire;

    assign w_rx     = r_sync[1];
    assign w_expire = (r_cnt == '0);
    assign o_byte   = r_shift;

    // Synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], i_rx};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        o_byte_valid = 1'b0;
        o_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    // Half a bit puts every later sample near mid-bit.
                    w_state_nxt = START;
                    w_cnt_nxt   = (i_div_eff >> 1) - ONE;
                end
            end
            START: begin
                if (w_expire) begin
                    if (!w_rx) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = i_div_eff - ONE;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_cnt_nxt   = i_div_eff - ONE;
                    if (r_bit == 3'd7) w_state_nxt = STOP;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            STOP: begin
                if (w_expire) begin
                    o_byte_valid = w_rx;
                    o_frame_err  = ~w_rx;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: register decode, 1-deep TX holding register and
// shifter, 1-byte RX buffer with overrun/frame flags, programmable divisor.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DIV_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_en,
    input  logic        uart_we,
    input  logic [1:0]  uart_addr,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(DIV_MIN);

    logic [DIV_W-1:0] r_baud;
    logic [DIV_W-1:0] w_div_eff;

    logic w_wr_tx, w_wr_stat, w_wr_baud, w_pop;

    logic             r_tx_full;
    logic [7:0]       r_tx_hold;
    uart_state_t      r_tx_state, w_tx_state_nxt;
    logic [DIV_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_bit, w_tx_bit_nxt;
    logic [7:0]       r_tx_shift, w_tx_shift_nxt;
    logic             r_tx, w_tx_nxt;
    logic             w_tx_load;
    logic             w_tx_busy;
    logic             w_tx_expire;

    logic       r_rx_valid, r_overrun, r_frame_err;
    logic [7:0] r_rx_byte;
    logic       w_rx_good, w_rx_ferr;
    logic [7:0] w_rx_byte;

    logic w_unused;

    assign w_unused  = ^uart_wdata[31:DIV_W];
    assign w_div_eff = (r_baud < MIN_DIV) ? MIN_DIV : r_baud;

    assign w_wr_tx   = uart_en & uart_we & (uart_addr == REG_TXDATA) & ~r_tx_full;
    assign w_wr_stat = uart_en & uart_we & (uart_addr == REG_STATUS);
    assign w_wr_baud = uart_en & uart_we & (uart_addr == REG_BAUD);
    assign w_pop     = uart_en & ~uart_we & (uart_addr == REG_RXDATA);

    assign w_tx_busy   = (r_tx_state != IDLE) | r_tx_full;
    assign w_tx_expire = (r_tx_cnt == '0);
    assign uart_tx     = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_baud <= DIV_W'(CLKS_PER_BIT);
        else if (w_wr_baud) r_baud <= uart_wdata[DIV_W-1:0];
    end

    // Write and shifter load never collide: a write needs full=0, a load needs full=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_full <= 1'b0;
            r_tx_hold <= '0;
        end else if (w_wr_tx) begin
            r_tx_full <= 1'b1;
            r_tx_hold <= uart_wdata[7:0];
        end else if (w_tx_load) begin
            r_tx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            IDLE: begin
                if (r_tx_full) begin
                    w_tx_load      = 1'b1;
                    w_tx_shift_nxt = r_tx_hold;
                    w_tx_state_nxt = START;
                    w_tx_cnt_nxt   = w_div_eff - ONE;
                end
            end
            START: begin
                if (w_tx_expire) begin
                    w_tx_state_nxt = DATA;
                    w_tx_cnt_nxt   = w_div_eff - ONE;
                    w_tx_bit_nxt   = '0;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - ONE;
                end
            end
            DATA: begin
                if (w_tx_expire) begin
                    w_tx_cnt_nxt = w_div_eff - ONE;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = STOP;
                    end else begin
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - ONE;
                end
            end
            STOP: begin
                if (w_tx_expire) begin
                    // A pending byte chains straight into its start bit.
                    if (r_tx_full) begin
                        w_tx_load      = 1'b1;
                        w_tx_shift_nxt = r_tx_hold;
                        w_tx_state_nxt = START;
                        w_tx_cnt_nxt   = w_div_eff - ONE;
                    end else begin
                        w_tx_state_nxt = IDLE;
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt - ONE;
                end
            end
            default: w_tx_state_nxt = IDLE;
        endcase

        case (w_tx_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_tx_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    uart_rx #(.DIV_W(DIV_W)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (uart_rx),
        .i_div_eff    (w_div_eff),
        .o_byte_valid (w_rx_good),
        .o_byte       (w_rx_byte),
        .o_frame_err  (w_rx_ferr)
    );

    // Error events take priority over a coincident write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_valid  <= 1'b0;
            r_rx_byte   <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_rx_good && (!r_rx_valid || w_pop)) begin
                r_rx_byte  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (w_pop) begin
                r_rx_valid <= 1'b0;
            end

            if (w_rx_good && r_rx_valid && !w_pop)
                r_overrun <= 1'b1;
            else if (w_wr_stat && uart_wdata[ST_OVERRUN])
                r_overrun <= 1'b0;

            if (w_rx_ferr)
                r_frame_err <= 1'b1;
            else if (w_wr_stat && uart_wdata[ST_FRAME_ERR])
                r_frame_err <= 1'b0;
        end
    end

    always_comb begin
        uart_rdata = '0;
        case (uart_addr)
            REG_RXDATA: uart_rdata = {24'b0, r_rx_byte};
            REG_STATUS: uart_rdata = {27'b0, r_frame_err, r_overrun, r_rx_valid, w_tx_busy, r_tx_full};
            REG_BAUD:   uart_rdata = 32'(r_baud);
            default:    uart_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register access, TX line shape, RX buffer and
// error flags, divisor floor, and asynchronous reset during a frame.
module tb_uart_mmio;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_en = 1'b0;
    logic        uart_we = 1'b0;
    logic [1:0]  uart_addr = 2'd0;
    logic [31:0] uart_wdata = 32'd0;
    logic [31:0] uart_rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]  rd;
    logic [159:0] cap;

    always #5 clk = ~clk;

    uart_mmio #(.CLKS_PER_BIT(868), .DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_en    (uart_en),
        .uart_we    (uart_we),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        uart_en = 1'b1; uart_we = 1'b1; uart_addr = a; uart_wdata = d;
        @(posedge clk);
        #1 uart_en = 1'b0; uart_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        uart_en = 1'b1; uart_we = 1'b0; uart_addr = a;
        #1 d = uart_rdata;
        @(posedge clk);
        #1 uart_en = 1'b0;
    endtask

    // Expected line samples, one per clock, for a frame at div clocks/bit.
    function automatic logic [159:0] frame_bits(input logic [7:0] b, input int div);
        logic [159:0] f;
        int idx;
        f = '0;
        for (int k = 0; k < 10 * div; k++) begin
            idx = k / div;
            if (idx == 0)      f[k] = 1'b0;
            else if (idx == 9) f[k] = 1'b1;
            else               f[k] = b[idx-1];
        end
        return f;
    endfunction

    task automatic capture(input int n, output logic [159:0] c);
        int t;
        c = '0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (uart_tx !== 1'b0 && t < 2000);
        chk("tx_start_seen", 160'(uart_tx), 160'd0);
        c[0] = uart_tx;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            c[k] = uart_tx;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int polls;
        int lows;

        // Reset state
        repeat (3) @(negedge clk);
        chk("tx_in_reset", 160'(uart_tx), 160'd1);
        rst = 1'b0;
        bus_rd(REG_STATUS, rd); chk("status_reset", 160'(rd), 160'h0);
        bus_rd(REG_BAUD, rd);   chk("baud_reset", 160'(rd), 160'd868);
        bus_rd(REG_TXDATA, rd); chk("txdata_reads_0", 160'(rd), 160'h0);
        chk("tx_idle", 160'(uart_tx), 160'd1);

        // Single frame 0xA5 at 8 clk/bit
        bus_wr(REG_BAUD, 32'h8);
        bus_rd(REG_BAUD, rd); chk("baud_8", 160'(rd), 160'd8);
        bus_wr(REG_TXDATA, 32'hA5);
        capture(80, cap);
        chk("frame_A5", cap, frame_bits(8'hA5, 8));
        bus_rd(REG_STATUS, rd); chk("busy_falls", 160'(rd), 160'h0);

        // Two chained frames, third write dropped while full
        fork
            capture(160, cap);
            begin
                bus_wr(REG_TXDATA, 32'h55);
                rd = 32'h1;
                polls = 0;
                while (rd[0] && polls < 10) begin
                    bus_rd(REG_STATUS, rd);
                    polls++;
                end
                chk("tx_full_clears", 160'(rd[0]), 160'd0);
                bus_wr(REG_TXDATA, 32'h0F);
                bus_wr(REG_TXDATA, 32'hFF);
                bus_rd(REG_STATUS, rd); chk("full_and_busy", 160'(rd), 160'h3);
            end
        join
        chk("frames_55_0F", cap, frame_bits(8'h55, 8) | (frame_bits(8'h0F, 8) << 80));
        lows = 0;
        repeat (120) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("third_byte_dropped", 160'(lows), 160'd0);
        bus_rd(REG_STATUS, rd); chk("status_after_pair", 160'(rd), 160'h0);

        // RX single byte and pop
        send_rx(8'h3C, 1'b1);
        bus_rd(REG_STATUS, rd); chk("rx_valid_set", 160'(rd), 160'h4);
        bus_rd(REG_RXDATA, rd); chk("rxdata_3C", 160'(rd), 160'h3C);
        bus_rd(REG_STATUS, rd); chk("rx_valid_popped", 160'(rd), 160'h0);

        // Overrun keeps first byte; W1C clears
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_rd(REG_STATUS, rd); chk("overrun_set", 160'(rd), 160'hC);
        bus_rd(REG_RXDATA, rd); chk("rxdata_11", 160'(rd), 160'h11);
        bus_rd(REG_STATUS, rd); chk("overrun_after_pop", 160'(rd), 160'h8);
        bus_wr(REG_STATUS, 32'h08);
        bus_rd(REG_STATUS, rd); chk("overrun_w1c", 160'(rd), 160'h0);

        // Framing error, stale read, glitch rejection
        send_rx(8'h5A, 1'b0);
        bus_rd(REG_STATUS, rd); chk("frame_err_set", 160'(rd), 160'h10);
        bus_rd(REG_RXDATA, rd); chk("stale_rxdata", 160'(rd), 160'h11);
        bus_rd(REG_STATUS, rd); chk("stale_read_no_effect", 160'(rd), 160'h10);
        bus_wr(REG_STATUS, 32'h10);
        bus_rd(REG_STATUS, rd); chk("frame_err_w1c", 160'(rd), 160'h0);
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk);
        @(negedge clk) uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        bus_rd(REG_STATUS, rd); chk("glitch_ignored", 160'(rd), 160'h0);

        // Divisor below the floor runs at 4 clk/bit
        bus_wr(REG_BAUD, 32'h2);
        bus_rd(REG_BAUD, rd); chk("baud_2_readback", 160'(rd), 160'd2);
        bus_wr(REG_TXDATA, 32'h81);
        capture(40, cap);
        chk("frame_81_div4", cap, frame_bits(8'h81, 4));

        // Reset in the middle of a frame
        bus_wr(REG_TXDATA, 32'h00);
        polls = 0;
        while (uart_tx !== 1'b0 && polls < 100) begin
            @(negedge clk);
            polls++;
        end
        repeat (6) @(negedge clk);
        chk("tx_low_midframe", 160'(uart_tx), 160'd0);
        #2 rst = 1'b1;
        #1 chk("tx_forced_high", 160'(uart_tx), 160'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_rd(REG_STATUS, rd); chk("status_after_rst", 160'(rd), 160'h0);
        bus_rd(REG_BAUD, rd);   chk("baud_after_rst", 160'(rd), 160'd868);
        bus_rd(REG_RXDATA, rd); chk("rxbyte_after_rst", 160'(rd), 160'h0);
        chk("tx_idle_after_rst", 160'(uart_tx), 160'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
